neuron_group_sequencer: RTL and testbench
=========================================

# neuron_group_sequencer

Parametrised, sequential successor to the combinational neuron selector. Sweeps the neuron array one group at a time: loads each group's stored membrane potential over a valid/ready handshake, drives the accumulator spike bus for a programmable number of cycles, then captures that group's updated potentials into a registered output with its own valid/ready handshake. Sits between the potential memory controller and the neuron array, and replaces per-cycle select lines from the top-level controller.

## Interface
- N_GROUPS, 64, number of neuron groups swept per run (≥2)
- GROUP_SIZE, 16, neurons per group
- POT_W, 8, potential width per neuron
- N_INPUTS, 1024, input spike lines per channel
- SPK_CH, 2, spike channels interleaved on spk_out
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin a sweep; ignored unless IDLE
- abort  in  1  terminate sweep; wins over all other inputs
- spk_sel  in  1  1: external spikes; 0: processed spikes; sampled on accepted start
- acc_len  in  8  ACC cycles per group; 0 treated as 1; sampled on accepted start
- in_spk  in  N_INPUTS  external spike vector
- processed_spk  in  SPK_CH  processed spike flags
- pin_data  in  GROUP_SIZE*POT_W  stored potentials for current group
- pin_valid  in  1  pin_data valid
- pin_ready  out  1  sequencer accepts pin_data
- potential_in_all  out  N_GROUPS*GROUP_SIZE*POT_W  pin_data broadcast to every group slice
- potential_in_ien_all  out  N_GROUPS*GROUP_SIZE  per-neuron load enable
- spk_out  out  SPK_CH*N_INPUTS  interleaved spikes; bit SPK_CH*z+c = channel c, line z
- potential_out_all  in  N_GROUPS*GROUP_SIZE*POT_W  updated potentials from the neuron array
- pout_data  out  GROUP_SIZE*POT_W  captured group potentials
- pout_valid  out  1  pout_data valid
- pout_ready  in  1  downstream accepts pout_data
- cur_group  out  clog2(N_GROUPS)  group being processed
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at end of a completed sweep

## Operation
- States: IDLE, LOAD, ACC, STORE, DONE.
- IDLE: start=1 → LOAD. Clears cur_group to 0 and latches spk_sel and acc_len.
- LOAD: pin_ready=1. potential_in_ien_all asserts the GROUP_SIZE bits of slice cur_group only in a cycle where pin_valid=1, i.e. the handshake cycle. All other enable bits are 0. A handshake moves the FSM to ACC and loads the ACC counter with max(acc_len,1)−1.
- potential_in_all always carries pin_data replicated into all slices. It is never X.
- ACC: spk_out is driven as follows.
  - Latched spk_sel=1: channel 0 = in_spk, other channels 0.
  - Latched spk_sel=0: channel c = all ones if processed_spk[c], otherwise all zeros.
  - Outside ACC, spk_out = 0.
  - The counter decrements each cycle. At 0 the FSM moves to STORE.
- STORE: on entry, pout_data captures slice cur_group of potential_out_all and pout_valid goes to 1. pout_data and pout_valid stay stable until pout_ready=1.
  - On handshake: if cur_group = N_GROUPS−1, go to DONE. Otherwise increment cur_group and go to LOAD.
- DONE: done=1 for one cycle, then IDLE.
- abort=1 in any state: next state IDLE. pout_valid, pin_ready, all ien bits and spk_out go to 0 on the next edge. No done pulse.
- start is ignored while busy. start and abort together in IDLE: stay in IDLE.

## Timing
- Reset values: state IDLE; cur_group 0; pout_data 0; pout_valid 0; pin_ready 0; done 0; busy 0; spk_out 0; all ien bits 0. potential_in_all follows pin_data.
- Reset asserted mid-sweep forces these values immediately (asynchronous).
- start accepted at edge 0 gives LOAD in cycle 1.
- With pin_valid held high and pout_ready held high, each group takes 1 (LOAD) + max(acc_len,1) (ACC) + 1 (STORE) cycles.
- done is asserted in cycle N_GROUPS*(max(acc_len,1)+2)+1.
- Stalls on pin_valid or pout_ready extend LOAD or STORE cycle for cycle. Nothing is dropped.
- pout_data is captured one edge after the last ACC cycle, so the neuron array has a one-cycle combinational settle.

## Configuration
- NSEQ_CYCLE_CNT_EN defined: adds output cycle_cnt [31:0].
  - Cleared to 0 on reset and on an accepted start.
  - Increments every cycle busy=1 and saturates at 0xFFFFFFFF.
  - Holds its value in IDLE.
- Not defined: the port and the counter logic are absent.

## Test plan
- Reset during ACC of group 5 → all outputs return to their reset values immediately; the next start begins at group 0.
- Full sweep with N_GROUPS=4, acc_len=3, pin_valid=1, pout_ready=1 → done in cycle 21; exactly four ien bursts, on slices 0..3 in order.
- spk_sel=0, processed_spk=2'b10 → during ACC spk_out = {1024{2'b10}}. spk_sel=1, in_spk=0xA5 in bits [7:0] → spk_out[15:0] = 0x4411.
- pout_ready held low for 7 cycles in STORE of group 2 → pout_data stable and equal to slice 2 throughout; cur_group stays 2.
- acc_len=0 → ACC lasts exactly 1 cycle. abort in LOAD → IDLE next cycle, no done, pin_ready 0.
- With NSEQ_CYCLE_CNT_EN, N_GROUPS=4, acc_len=3 → cycle_cnt = 21 after done, then holds.

Source files
------------

// File: rtl/neuron_group_sequencer_if.sv
// neuron_group_sequencer_if: potential load (pin) and store (pout) valid/ready buses
interface neuron_group_sequencer_if #(
  parameter int GROUP_SIZE = 16,
  parameter int POT_W      = 8
);
  logic [GROUP_SIZE*POT_W-1:0] pin_data;
  logic                        pin_valid;
  logic                        pin_ready;
  logic [GROUP_SIZE*POT_W-1:0] pout_data;
  logic                        pout_valid;
  logic                        pout_ready;
  modport master (input pin_data, pin_valid, pout_ready, output pin_ready, pout_data, pout_valid);
  modport slave  (output pin_data, pin_valid, pout_ready, input pin_ready, pout_data, pout_valid);
endinterface

// File: rtl/neuron_group_sequencer.sv
// neuron_group_sequencer: sweeps neuron groups load->accumulate->store; NSEQ_CYCLE_CNT_EN adds cycle_cnt
module neuron_group_sequencer #(
  parameter int N_GROUPS   = 64,
  parameter int GROUP_SIZE = 16,
  parameter int POT_W      = 8,
  parameter int N_INPUTS   = 1024,
  parameter int SPK_CH     = 2
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic                                  abort,
  input  logic                                  spk_sel,
  input  logic [7:0]                            acc_len,
  input  logic [N_INPUTS-1:0]                   in_spk,
  input  logic [SPK_CH-1:0]                     processed_spk,
  neuron_group_sequencer_if.master              bus,
  output logic [N_GROUPS*GROUP_SIZE*POT_W-1:0]  potential_in_all,
  output logic [N_GROUPS*GROUP_SIZE-1:0]        potential_in_ien_all,
  output logic [SPK_CH*N_INPUTS-1:0]            spk_out,
  input  logic [N_GROUPS*GROUP_SIZE*POT_W-1:0]  potential_out_all,
  output logic [$clog2(N_GROUPS)-1:0]           cur_group,
  output logic                                  busy,
`ifdef NSEQ_CYCLE_CNT_EN
  output logic [31:0]                           cycle_cnt,
`endif
  output logic                                  done
);
  localparam int GW = $clog2(N_GROUPS);
  localparam int GB = GROUP_SIZE*POT_W;
  localparam logic [GW-1:0] LAST = GW'(N_GROUPS-1);
  typedef enum logic [2:0] {IDLE, LOAD, ACC, STORE, DONE} state_t;
  state_t state, nxt;
  logic [7:0] len_q, cnt;
  logic sel_q;
  logic [GB-1:0] pout_q;
  logic accept;
  assign accept = state == IDLE && start && !abort;
  assign potential_in_all = {N_GROUPS{bus.pin_data}};
  assign bus.pin_ready = state == LOAD;
  assign bus.pout_valid = state == STORE;
  assign bus.pout_data = pout_q;
  assign busy = state != IDLE;
  assign done = state == DONE;
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nxt;
  // next-state: abort overrides every transition
  always_comb begin
    nxt = state;
    case (state)
      IDLE:  nxt = start ? LOAD : IDLE;
      LOAD:  nxt = bus.pin_valid ? ACC : LOAD;
      ACC:   nxt = cnt == 8'd0 ? STORE : ACC;
      STORE: nxt = bus.pout_ready ? (cur_group == LAST ? DONE : LOAD) : STORE;
      DONE:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
    if (abort) nxt = IDLE;
  end
  // sweep datapath: latched config, ACC counter, group index, captured potentials
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cur_group <= '0;
      sel_q <= 1'b0;
      len_q <= 8'd0;
      cnt <= 8'd0;
      pout_q <= '0;
    end else begin
      if (accept) begin
        cur_group <= '0;
        sel_q <= spk_sel;
        len_q <= acc_len == 8'd0 ? 8'd0 : acc_len - 8'd1;
      end
      if (state == LOAD && nxt == ACC) cnt <= len_q;
      if (state == ACC && cnt != 8'd0) cnt <= cnt - 8'd1;
      if (state == ACC && nxt == STORE) pout_q <= potential_out_all[GB*int'(cur_group) +: GB];
      if (state == STORE && nxt == LOAD) cur_group <= cur_group + GW'(1);
    end
  // load enables only for the current slice, only in the handshake cycle
  always_comb begin
    potential_in_ien_all = '0;
    if (bus.pin_ready && bus.pin_valid) potential_in_ien_all[GROUP_SIZE*int'(cur_group) +: GROUP_SIZE] = '1;
  end
  // interleaved spike bus, driven only while accumulating
  always_comb begin
    spk_out = '0;
    for (int z = 0; z < N_INPUTS; z++)
      for (int c = 0; c < SPK_CH; c++)
        spk_out[SPK_CH*z+c] = state == ACC && (sel_q ? (c == 0 && in_spk[z]) : processed_spk[c]);
  end
`ifdef NSEQ_CYCLE_CNT_EN
  // busy-cycle counter, saturating, cleared on accepted start
  always_ff @(posedge clk or posedge rst)
    if (rst) cycle_cnt <= 32'd0;
    else if (accept) cycle_cnt <= 32'd0;
    else if (busy && cycle_cnt != 32'hFFFF_FFFF) cycle_cnt <= cycle_cnt + 32'd1;
`endif
endmodule

// File: tb/tb_neuron_group_sequencer.sv
// tb_neuron_group_sequencer: directed checks of sweep timing, spikes, stalls, abort and reset
module tb_neuron_group_sequencer;
  localparam int NG = 8, GS = 4, PW = 8, NI = 16, SC = 2;
  logic clk = 1'b0, rst, start, abort, spk_sel;
  logic [7:0] acc_len;
  logic [NI-1:0] in_spk;
  logic [SC-1:0] processed_spk;
  logic [NG*GS*PW-1:0] potential_in_all, potential_out_all;
  logic [NG*GS-1:0] ien;
  logic [SC*NI-1:0] spk_out;
  logic [2:0] cur_group;
  logic busy, done;
`ifdef NSEQ_CYCLE_CNT_EN
  logic [31:0] cycle_cnt;
`endif
  int n_checks = 0, n_fail = 0;
  neuron_group_sequencer_if #(.GROUP_SIZE(GS), .POT_W(PW)) bus ();
  neuron_group_sequencer #(.N_GROUPS(NG), .GROUP_SIZE(GS), .POT_W(PW), .N_INPUTS(NI), .SPK_CH(SC)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .spk_sel(spk_sel), .acc_len(acc_len),
    .in_spk(in_spk), .processed_spk(processed_spk), .bus(bus), .potential_in_all(potential_in_all),
    .potential_in_ien_all(ien), .spk_out(spk_out), .potential_out_all(potential_out_all),
    .cur_group(cur_group), .busy(busy),
`ifdef NSEQ_CYCLE_CNT_EN
    .cycle_cnt(cycle_cnt),
`endif
    .done(done));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(negedge clk);
    #1;
  endtask
  function automatic logic [31:0] slice_of(input int g);
    logic [31:0] s;
    for (int j = 0; j < GS; j++) s[8*j +: 8] = 8'(g*16 + j);
    return s;
  endfunction
  initial begin
    int nb, bad_burst, bad_spk, bad_pout, n_pout, acc_cycles, n_done, done_cyc, stall_bad;
    bit found;
    rst = 1'b1; start = 1'b0; abort = 1'b0; spk_sel = 1'b0; acc_len = 8'd0;
    in_spk = '0; processed_spk = '0;
    bus.pin_data = 32'hCAFE_0123; bus.pin_valid = 1'b0; bus.pout_ready = 1'b0;
    for (int g = 0; g < NG; g++) potential_out_all[32*g +: 32] = slice_of(g);
    step; step;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pin_ready", bus.pin_ready, 0);
    check("rst_pout_valid", bus.pout_valid, 0);
    check("rst_pout_data", bus.pout_data, 0);
    check("rst_spk", spk_out, 0);
    check("rst_ien", ien, 0);
    check("rst_group", cur_group, 0);
    check("pin_bcast", potential_in_all, {NG{32'hCAFE_0123}});
    rst = 1'b0;
    step;
    // full sweep, processed spikes 2'b10, acc_len 3: done expected in cycle 8*5+1 = 41
    acc_len = 8'd3; spk_sel = 1'b0; processed_spk = 2'b10; bus.pin_valid = 1'b1; bus.pout_ready = 1'b1;
    start = 1'b1;
    step;
    start = 1'b0;
    nb = 0; bad_burst = 0; bad_spk = 0; bad_pout = 0; n_pout = 0; acc_cycles = 0; n_done = 0; done_cyc = 0;
    for (int cyc = 1; cyc < 100; cyc++) begin
      if (ien != 0) begin
        if (ien !== (32'hF << (4*nb))) bad_burst++;
        nb++;
      end
      if (spk_out != 0) begin
        acc_cycles++;
        if (spk_out !== {NI{2'b10}}) bad_spk++;
      end
      if (bus.pout_valid) begin
        n_pout++;
        if (bus.pout_data !== slice_of(n_pout - 1)) bad_pout++;
      end
      if (done) begin
        n_done++;
        if (done_cyc == 0) done_cyc = cyc;
      end
      if (done_cyc != 0 && !busy) break;
      step;
    end
    check("sweep_done_cycle", done_cyc, 41);
    check("sweep_done_pulses", n_done, 1);
    check("sweep_bursts", nb, 8);
    check("sweep_burst_order", bad_burst, 0);
    check("sweep_acc_cycles", acc_cycles, 24);
    check("sweep_spk_value", bad_spk, 0);
    check("sweep_store_cycles", n_pout, 8);
    check("sweep_pout_data", bad_pout, 0);
    check("sweep_idle_busy", busy, 0);
`ifdef NSEQ_CYCLE_CNT_EN
    check("cycle_cnt", cycle_cnt, 41);
    step; step; step;
    check("cycle_cnt_hold", cycle_cnt, 41);
`endif
    // external spikes, acc_len 0 -> single ACC cycle; then abort in STORE
    spk_sel = 1'b1; in_spk = 16'h00A5; acc_len = 8'd0; bus.pout_ready = 1'b0;
    start = 1'b1;
    step;
    start = 1'b0;
    check("ext_load_ien", ien, 32'h0000_000F);
    check("ext_load_ready", bus.pin_ready, 1);
    step;
    check("ext_spk", spk_out, 32'h0000_4411);
    step;
    check("acc0_spk_off", spk_out, 0);
    check("acc0_store", bus.pout_valid, 1);
    check("acc0_pout", bus.pout_data, slice_of(0));
    abort = 1'b1;
    step;
    abort = 1'b0;
    check("abort_store_busy", busy, 0);
    check("abort_store_pout_valid", bus.pout_valid, 0);
    // abort in LOAD
    bus.pin_valid = 1'b0;
    start = 1'b1;
    step;
    start = 1'b0;
    check("load_ready", bus.pin_ready, 1);
    abort = 1'b1; bus.pin_valid = 1'b1;
    step;
    abort = 1'b0;
    check("abort_load_busy", busy, 0);
    check("abort_load_ready", bus.pin_ready, 0);
    check("abort_load_ien", ien, 0);
    check("abort_load_done", done, 0);
    step;
    check("abort_load_no_done", done, 0);
    // start and abort together in IDLE
    start = 1'b1; abort = 1'b1;
    step;
    start = 1'b0; abort = 1'b0;
    check("start_abort_idle", busy, 0);
    // pout_ready stall of 7 cycles in STORE of group 2
    spk_sel = 1'b0; processed_spk = 2'b01; acc_len = 8'd1; bus.pout_ready = 1'b1;
    start = 1'b1;
    step;
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.pout_valid && cur_group == 3'd2) begin
        found = 1'b1;
        break;
      end
      step;
    end
    check("stall_reach", found, 1);
    bus.pout_ready = 1'b0;
    stall_bad = 0;
    for (int i = 0; i < 7; i++) begin
      step;
      if (bus.pout_data !== slice_of(2) || cur_group !== 3'd2 || !bus.pout_valid) stall_bad++;
    end
    check("stall_stable", stall_bad, 0);
    bus.pout_ready = 1'b1;
    step;
    check("stall_release_group", cur_group, 3);
    check("stall_release_load", bus.pin_ready, 1);
    abort = 1'b1;
    step;
    abort = 1'b0;
    // asynchronous reset during ACC of group 5
    acc_len = 8'd3; processed_spk = 2'b11;
    start = 1'b1;
    step;
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (cur_group == 3'd5 && spk_out != 0) begin
        found = 1'b1;
        break;
      end
      step;
    end
    check("rst_acc_reach", found, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_spk", spk_out, 0);
    check("arst_group", cur_group, 0);
    check("arst_pout_data", bus.pout_data, 0);
    check("arst_pout_valid", bus.pout_valid, 0);
    check("arst_pin_ready", bus.pin_ready, 0);
    check("arst_ien", ien, 0);
    step;
    rst = 1'b0;
    step;
    start = 1'b1;
    step;
    start = 1'b0;
    check("restart_group", cur_group, 0);
    check("restart_ien", ien, 32'h0000_000F);
    abort = 1'b1;
    step;
    abort = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
